fp_mult_core_seq: RTL and testbench
===================================

FP_MULT_CORE_SEQ -- requirements
Module: fp_mult_core_seq

Purpose: iterative front-end of the single-precision multiplier. Unpacks two IEEE-754 operands and produces the raw 48-bit significand product P and exponent sum S consumed by the multiplier normalization stage.

Interface
REQ-001 SHALL have parameter STEP, default 1: product bits retired per BUSY cycle; legal values 1, 2, 3, 4, 6, 8, 12, 24.
REQ-002 SHALL define N = 24/STEP as the BUSY cycle count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  operand pair a/b is valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  32  IEEE-754 single operand A.
REQ-008 b  input  32  IEEE-754 single operand B.
REQ-009 out_valid  output  1  P/S/sign are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 P  output  48  unsigned significand product {hA,mA}*{hB,mB}.
REQ-012 S  output  9  unbiased exponent sum eA+eB; bias removal is done downstream.
REQ-013 sign  output  1  a[31] XOR b[31].

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On accept (in_valid & in_ready at an edge), the block SHALL:
- register the 24-bit significands, with hidden bit h = |exponent (so exponent 0 gives h = 0);
- register S = {0,a[30:23]} + {0,b[30:23]}, with no overflow possible in 9 bits;
- register sign;
- clear the accumulator and the iteration counter;
- go to BUSY.
REQ-017 In each BUSY cycle the block SHALL add (multiplicand × the next STEP multiplier bits, LSB first), shifted by the bit position, into the 48-bit accumulator, and advance the counter by 1.
REQ-018 After the N-th BUSY edge the accumulator SHALL equal the exact product, and the FSM SHALL go to DONE.
REQ-019 Latency: if the accept edge is at cycle 0, out_valid SHALL first be 1 in cycle N+1 (STEP=1: cycle 25).
REQ-020 The datapath SHALL NOT shortcut zero or special operands; latency is data-independent.
REQ-021 While out_valid = 1 and out_ready = 0, P, S and sign SHALL hold stable.
REQ-022 On an edge with out_valid & out_ready, the FSM SHALL go to IDLE, and in_ready SHALL be 1 in the next cycle; there is no same-cycle re-accept.
REQ-023 in_valid, a and b SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-024 P and S SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-025 NaN, infinity and denormal classification SHALL NOT be performed here; those are handled in the downstream exception stage.

Reset
REQ-026 An edge with rst_n = 0 SHALL force IDLE, P = 0, S = 0, sign = 0, out_valid = 0, and clear the counter, from any state including mid-BUSY.
REQ-027 in_ready SHALL be 0 while rst_n = 0 and 1 in the first cycle after the release edge.
REQ-028 An operation interrupted by reset SHALL produce no out_valid pulse.

Verification
REQ-029 STEP=1, a = b = 0x3F800000 -> out_valid exactly 25 cycles after accept; P = 0x400000000000, S = 254, sign = 0.
REQ-030 a = b = 0x3FC00000 -> P = 0x900000000000 (P[47] = 1), S = 254.
REQ-031 a = 0xC0000000, b = 0x40400000 -> P = 0x600000000000, S = 256, sign = 1.
REQ-032 a = b = 0x7F7FFFFF -> P = 0xFFFFFE000001, S = 508; a = 0x00000000, b = 0x3F800000 -> P = 0, S = 127.
REQ-033 Backpressure and reset:
- hold out_ready = 0 for 10 cycles in DONE -> outputs stable and in_ready = 0 throughout;
- pulse in_valid during BUSY -> ignored;
- assert rst_n = 0 at BUSY cycle 12 -> IDLE, P = 0, no out_valid.
REQ-034 Repeat REQ-029 to REQ-032 for STEP = 4 and 24 -> identical results, out_valid at cycles 7 and 2 respectively.

Source files
------------

// File: rtl/fp_mult_core_seq.sv
// Iterative significand multiplier front-end: unpacks two single-precision operands and
// retires STEP multiplier bits per cycle into a 48-bit product, alongside the raw exponent sum.
module fp_mult_core_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] P,
    output logic [8:0]  S,
    output logic        sign
);

    localparam int N = 24 / STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [47:0] mcand_q;
    logic [23:0] mplier_q;
    logic [47:0] acc_q;
    logic [47:0] acc_d;
    logic [8:0]  exp_sum_q;
    logic        sign_q;
    logic [4:0]  cnt_q;

    // One shifted copy of the multiplicand per multiplier bit consumed this cycle.
    logic [47:0] pp [STEP];
    logic [47:0] step_sum;

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : 48'd0;
        end
    endgenerate

    always_comb begin
        step_sum = 48'd0;
        for (int i = 0; i < STEP; i++) begin
            step_sum = step_sum + pp[i];
        end
    end

    assign acc_d = acc_q + step_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= 48'd0;
            mplier_q    <= 24'd0;
            acc_q       <= 48'd0;
            exp_sum_q   <= 9'd0;
            sign_q      <= 1'b0;
            cnt_q       <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    // in_ready_q is still low on the reset-release edge, so no accept there.
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= {24'd0, |a[30:23], a[22:0]};
                        mplier_q   <= {|b[30:23], b[22:0]};
                        exp_sum_q  <= {1'b0, a[30:23]} + {1'b0, b[30:23]};
                        sign_q     <= a[31] ^ b[31];
                        acc_q      <= 48'd0;
                        cnt_q      <= 5'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << STEP;
                    mplier_q <= mplier_q >> STEP;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'(N - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = acc_q;
    assign S         = exp_sum_q;
    assign sign      = sign_q;

endmodule

// File: tb/tb_fp_mult_core_seq.sv
// Randomized and directed checks of fp_mult_core_seq for STEP = 1, 4 and 24 against
// a plain-arithmetic model of the unpacked significand product and exponent sum.
module tb_fp_mult_core_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst_n_v;
    logic [2:0]        in_valid_v;
    logic [2:0]        in_ready_v;
    logic [2:0][31:0]  a_v;
    logic [2:0][31:0]  b_v;
    logic [2:0]        out_valid_v;
    logic [2:0]        out_ready_v;
    logic [2:0][47:0]  p_v;
    logic [2:0][8:0]   s_v;
    logic [2:0]        sign_v;

    fp_mult_core_seq #(.STEP(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .P(p_v[0]), .S(s_v[0]), .sign(sign_v[0])
    );
    fp_mult_core_seq #(.STEP(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .P(p_v[1]), .S(s_v[1]), .sign(sign_v[1])
    );
    fp_mult_core_seq #(.STEP(24)) u_dut_s24 (
        .clk(clk), .rst_n(rst_n_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .P(p_v[2]), .S(s_v[2]), .sign(sign_v[2])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 24);
    endfunction

    // Reference: significand with hidden bit = |exponent, exact product, exponent sum, sign xor.
    function automatic logic [47:0] ref_p(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] mx;
        logic [47:0] my;
        mx = (x[30:23] != 8'd0) ? (48'h800000 + 48'(x[22:0])) : 48'(x[22:0]);
        my = (y[30:23] != 8'd0) ? (48'h800000 + 48'(y[22:0])) : 48'(y[22:0]);
        return mx * my;
    endfunction

    function automatic logic [8:0] ref_s(input logic [31:0] x, input logic [31:0] y);
        return 9'(x[30:23]) + 9'(y[30:23]);
    endfunction

    task automatic do_reset(input int k);
        rst_n_v[k] = 1'b0;
        tick;
        tick;
        check($sformatf("s%0d rst in_ready", step_of(k)), 64'(in_ready_v[k]), 64'd0);
        check($sformatf("s%0d rst out_valid", step_of(k)), 64'(out_valid_v[k]), 64'd0);
        check($sformatf("s%0d rst P", step_of(k)), 64'(p_v[k]), 64'd0);
        check($sformatf("s%0d rst S", step_of(k)), 64'(s_v[k]), 64'd0);
        check($sformatf("s%0d rst sign", step_of(k)), 64'(sign_v[k]), 64'd0);
        rst_n_v[k] = 1'b1;
        tick;
        check($sformatf("s%0d release in_ready", step_of(k)), 64'(in_ready_v[k]), 64'd1);
    endtask

    task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                         input logic [47:0] ep, input logic [8:0] es, input logic esg,
                         input int hold);
        int n;
        int w;
        int lat;
        bit got;
        string id;
        n = 24 / step_of(k);
        id = $sformatf("s%0d a=%08h b=%08h", step_of(k), av, bv);
        w = 0;
        while (!in_ready_v[k] && w < 60) begin
            tick;
            w++;
        end
        check({id, " ready"}, 64'(in_ready_v[k]), 64'd1);
        in_valid_v[k] = 1'b1;
        a_v[k] = av;
        b_v[k] = bv;
        tick;
        got = 1'b0;
        lat = 0;
        // Inputs and out_ready toggle randomly while busy; all of it must be ignored.
        for (int c = 1; c <= n + 4 && !got; c++) begin
            in_valid_v[k]  = 1'($urandom);
            a_v[k]         = $urandom;
            b_v[k]         = $urandom;
            out_ready_v[k] = 1'($urandom);
            tick;
            if (out_valid_v[k]) begin
                got = 1'b1;
                lat = c + 1;
            end
        end
        out_ready_v[k] = 1'b0;
        in_valid_v[k]  = 1'b0;
        check({id, " latency"}, 64'(lat), 64'(n + 1));
        check({id, " P"}, 64'(p_v[k]), 64'(ep));
        check({id, " S"}, 64'(s_v[k]), 64'(es));
        check({id, " sign"}, 64'(sign_v[k]), 64'(esg));
        for (int h = 0; h < hold; h++) begin
            tick;
            check({id, " hold P"}, 64'(p_v[k]), 64'(ep));
            check({id, " hold S"}, 64'(s_v[k]), 64'(es));
            check({id, " hold sign"}, 64'(sign_v[k]), 64'(esg));
            check({id, " hold out_valid"}, 64'(out_valid_v[k]), 64'd1);
            check({id, " hold in_ready"}, 64'(in_ready_v[k]), 64'd0);
        end
        out_ready_v[k] = 1'b1;
        in_valid_v[k]  = 1'b1;
        a_v[k] = $urandom;
        b_v[k] = $urandom;
        tick;
        out_ready_v[k] = 1'b0;
        in_valid_v[k]  = 1'b0;
        check({id, " post out_valid"}, 64'(out_valid_v[k]), 64'd0);
        check({id, " post in_ready"}, 64'(in_ready_v[k]), 64'd1);
        $display("txn %s -> P=%012h S=%0d sign=%0d lat=%0d", id, ep, es, esg, lat);
    endtask

    task automatic do_mid_reset(input int k);
        int n;
        int r;
        bit seen;
        n = 24 / step_of(k);
        r = (n > 12) ? 11 : n - 1;
        in_valid_v[k] = 1'b1;
        a_v[k] = 32'h7F7FFFFF;
        b_v[k] = 32'h7F7FFFFF;
        tick;
        in_valid_v[k] = 1'b0;
        for (int i = 0; i < r; i++) tick;
        rst_n_v[k] = 1'b0;
        tick;
        check($sformatf("s%0d midrst in_ready", step_of(k)), 64'(in_ready_v[k]), 64'd0);
        check($sformatf("s%0d midrst out_valid", step_of(k)), 64'(out_valid_v[k]), 64'd0);
        check($sformatf("s%0d midrst P", step_of(k)), 64'(p_v[k]), 64'd0);
        rst_n_v[k] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < n + 3; i++) begin
            tick;
            if (out_valid_v[k]) seen = 1'b1;
        end
        check($sformatf("s%0d midrst no out_valid", step_of(k)), 64'(seen), 64'd0);
        check($sformatf("s%0d midrst idle", step_of(k)), 64'(in_ready_v[k]), 64'd1);
        $display("txn s%0d reset after %0d busy edges", step_of(k), r);
    endtask

    logic [31:0] dir_a [5] = '{32'h3F800000, 32'h3FC00000, 32'hC0000000, 32'h7F7FFFFF, 32'h00000000};
    logic [31:0] dir_b [5] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h7F7FFFFF, 32'h3F800000};
    logic [47:0] dir_p [5] = '{48'h400000000000, 48'h900000000000, 48'h600000000000,
                               48'hFFFFFE000001, 48'h000000000000};
    logic [8:0]  dir_s [5] = '{9'd254, 9'd254, 9'd256, 9'd508, 9'd127};
    logic        dir_g [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n_v     = 3'b000;
        in_valid_v  = 3'b000;
        out_ready_v = 3'b000;
        a_v = '0;
        b_v = '0;
        for (int k = 0; k < 3; k++) begin
            do_reset(k);
            for (int d = 0; d < 5; d++) begin
                do_op(k, dir_a[d], dir_b[d], dir_p[d], dir_s[d], dir_g[d], (d == 0) ? 10 : 0);
            end
            for (int t = 0; t < 20; t++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom;
                rb = $urandom;
                if ($urandom_range(0, 3) == 0) ra[30:23] = 8'd0;
                if ($urandom_range(0, 3) == 0) rb[30:23] = 8'd0;
                do_op(k, ra, rb, ref_p(ra, rb), ref_s(ra, rb), ra[31] ^ rb[31],
                      int'($urandom_range(0, 3)));
            end
            do_mid_reset(k);
            do_op(k, 32'h3FC00000, 32'h3FC00000, ref_p(32'h3FC00000, 32'h3FC00000),
                  ref_s(32'h3FC00000, 32'h3FC00000), 1'b0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
